// File: rtl/key_pkg.sv
// Shared keyboard definitions: key indices, scancode-set-2 constants, decoder states
// and the scancode-to-key lookup used by the controller.
package key_pkg;

  localparam int KEY_NUM = 6;

  typedef enum logic [2:0] {
    LEFT  = 3'd0,
    RIGHT = 3'd1,
    UP    = 3'd2,
    DOWN  = 3'd3,
    JUMP  = 3'd4,
    START = 3'd5
  } key_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_JUMP  = 8'h29;
  localparam logic [7:0] SC_START = 8'h5A;

  // One-hot key mask for a code; arrows need the E0 prefix, JUMP/START must not have it.
  function automatic logic [KEY_NUM-1:0] key_mask(input logic [7:0] code, input logic ext);
    logic [KEY_NUM-1:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  m[LEFT]  = 1'b1;
        SC_RIGHT: m[RIGHT] = 1'b1;
        SC_UP:    m[UP]    = 1'b1;
        SC_DOWN:  m[DOWN]  = 1'b1;
        default:  m        = '0;
      endcase
    end else begin
      case (code)
        SC_JUMP:  m[JUMP]  = 1'b1;
        SC_START: m[START] = 1'b1;
        default:  m        = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode decoder producing a live held-key vector, re-timed to the video frame
// as a frame-stable vector plus per-frame press events.
module ps2_key_ctrl
  import key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               frame_start,
  output logic [KEY_NUM-1:0] key_held,
  output logic [KEY_NUM-1:0] key_frame,
  output logic [KEY_NUM-1:0] key_press,
  output logic               timeout_evt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  kbd_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [KEY_NUM-1:0] r_held;
  logic [KEY_NUM-1:0] r_frame;
  logic [KEY_NUM-1:0] r_press;
  logic [KEY_NUM-1:0] r_acc;
  logic               r_tmo_evt;

  kbd_state_e         w_state_nxt;
  logic               w_make;
  logic               w_brk;
  logic               w_ext;
  logic               w_tmo;
  logic [KEY_NUM-1:0] w_mask;
  logic [KEY_NUM-1:0] w_held_nxt;
  logic [KEY_NUM-1:0] w_rise;

  // Byte decode: next state, make/break classification and the resulting held vector.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == SC_EXT) begin
            w_state_nxt = EXT;
          end else if (rx_data == SC_BRK) begin
            w_state_nxt = BRK;
          end else begin
            w_make = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXT: begin
        w_ext = 1'b1;
        if (rx_valid) begin
          if (rx_data == SC_BRK) begin
            w_state_nxt = EXT_BRK;
          end else if (rx_data == SC_EXT) begin
            w_state_nxt = EXT;
          end else begin
            w_make      = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = EXT;
        end
      end
      BRK: begin
        if (rx_valid) begin
          w_brk       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BRK;
        end
      end
      EXT_BRK: begin
        w_ext = 1'b1;
        if (rx_valid) begin
          w_brk       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = EXT_BRK;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A byte landing on the last count wins over the timeout.
    if (r_state != IDLE && !rx_valid && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      w_tmo       = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      w_tmo = 1'b0;
    end

    w_mask = key_mask(rx_data, w_ext);
    if (w_make) begin
      w_held_nxt = r_held | w_mask;
    end else if (w_brk) begin
      w_held_nxt = r_held & ~w_mask;
    end else begin
      w_held_nxt = r_held;
    end
    w_rise = w_held_nxt & ~r_held;
  end

  // Decoder state, prefix timeout counter, held vector and frame latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_held    <= '0;
      r_frame   <= '0;
      r_press   <= '0;
      r_acc     <= '0;
      r_tmo_evt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_held    <= w_held_nxt;
      r_tmo_evt <= w_tmo;

      if (rx_valid || r_state == IDLE || w_tmo) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // The frame sees the pre-byte held vector; a same-cycle edge seeds the new accumulator.
      if (frame_start) begin
        r_frame <= r_held;
        r_press <= r_acc;
        r_acc   <= w_rise;
      end else begin
        r_acc   <= r_acc | w_rise;
      end
    end
  end

  assign key_held    = r_held;
  assign key_frame   = r_frame;
  assign key_press   = r_press;
  assign timeout_evt = r_tmo_evt;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: scancode sequences, frame re-timing, prefix timeout, reset.
module tb_ps2_key_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_start;
  logic [5:0] key_held;
  logic [5:0] key_frame;
  logic [5:0] key_press;
  logic       timeout_evt;

  int n_cmp;
  int n_fail;

  ps2_key_ctrl #(.TIMEOUT_CYCLES(65_000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_start (frame_start),
    .key_held    (key_held),
    .key_frame   (key_frame),
    .key_press   (key_press),
    .timeout_evt (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the following falling edge is one rising edge later.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic send_with_frame(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    rx_valid    = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    rx_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  int first_hit;
  int hits;

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_held",  {26'd0, key_held},  32'h0);
    check("rst_frame", {26'd0, key_frame}, 32'h0);
    check("rst_press", {26'd0, key_press}, 32'h0);
    check("rst_tmo",   {31'd0, timeout_evt}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: JUMP make, two frames, then release
    send(8'h29);
    check("t1_held", {26'd0, key_held}, 32'h10);
    check("t1_frame_pre", {26'd0, key_frame}, 32'h0);
    frame();
    check("t1_frame", {26'd0, key_frame}, 32'h10);
    check("t1_press", {26'd0, key_press}, 32'h10);
    frame();
    check("t1_frame2", {26'd0, key_frame}, 32'h10);
    check("t1_press2", {26'd0, key_press}, 32'h0);
    send(8'hF0);
    check("t1_held_f0", {26'd0, key_held}, 32'h10);
    send(8'h29);
    check("t1_rel", {26'd0, key_held}, 32'h0);
    frame();
    check("t1_frame3", {26'd0, key_frame}, 32'h0);
    check("t1_press3", {26'd0, key_press}, 32'h0);

    // 2: LEFT tap inside one frame
    send(8'hE0);
    send(8'h6B);
    check("t2_held_on", {26'd0, key_held}, 32'h01);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check("t2_held_off", {26'd0, key_held}, 32'h0);
    frame();
    check("t2_frame", {26'd0, key_frame}, 32'h0);
    check("t2_press", {26'd0, key_press}, 32'h01);
    frame();
    check("t2_press2", {26'd0, key_press}, 32'h0);

    // 3: codes with the wrong prefix are ignored; decoder then still accepts JUMP
    send(8'h6B);
    check("t3_plain6b", {26'd0, key_held}, 32'h0);
    send(8'hE0);
    send(8'h5A);
    check("t3_e05a", {26'd0, key_held}, 32'h0);
    frame();
    check("t3_press", {26'd0, key_press}, 32'h0);
    send(8'h29);
    check("t3_idle_after", {26'd0, key_held}, 32'h10);
    send(8'hF0);
    send(8'h29);
    frame();
    check("t3_press_j", {26'd0, key_press}, 32'h10);
    frame();
    check("t3_press_j2", {26'd0, key_press}, 32'h0);

    // 4: prefix timeout; pulse visible after the 65000th edge following the E0 edge
    send(8'hE0);
    first_hit = -1;
    hits      = 0;
    for (int k = 1; k <= 65_010; k++) begin
      @(negedge clk);
      if (timeout_evt) begin
        hits++;
        if (first_hit < 0) first_hit = k;
      end
    end
    check("t4_first", first_hit, 32'd65000);
    check("t4_hits",  hits,      32'd1);
    send(8'h75);
    check("t4_held_75", {26'd0, key_held}, 32'h0);

    // 5: UP typematic repeats give one press event
    send(8'hE0);
    send(8'h75);
    check("t5_held", {26'd0, key_held}, 32'h04);
    frame();
    check("t5_press", {26'd0, key_press}, 32'h04);
    hits = 0;
    for (int r = 0; r < 10; r++) begin
      send(8'hE0);
      send(8'h75);
      if (r % 3 == 2) begin
        frame();
        if (key_press[2]) hits++;
      end
    end
    frame();
    if (key_press[2]) hits++;
    check("t5_rep_press", hits, 32'd0);
    check("t5_rep_held", {26'd0, key_held}, 32'h04);
    send_with_frame(8'h29);
    check("t5_coinc_held",  {26'd0, key_held},  32'h14);
    check("t5_coinc_frame", {26'd0, key_frame}, 32'h04);
    check("t5_coinc_press", {26'd0, key_press}, 32'h0);
    frame();
    check("t5_next_frame", {26'd0, key_frame}, 32'h14);
    check("t5_next_press", {26'd0, key_press}, 32'h10);

    // 6: async reset after E0 F0, then 74 is a non-extended, unmapped make
    send(8'hE0);
    send(8'hF0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_held",  {26'd0, key_held},  32'h0);
    check("t6_frame", {26'd0, key_frame}, 32'h0);
    check("t6_press", {26'd0, key_press}, 32'h0);
    check("t6_tmo",   {31'd0, timeout_evt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h74);
    check("t6_74", {26'd0, key_held}, 32'h0);
    send(8'h29);
    check("t6_jump", {26'd0, key_held}, 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
